// File: rtl/wbgpio_pkg.sv
// Shared constants for the Wishbone GPIO/interrupt block: register map and field width.
package wbgpio_pkg;
  localparam int FW = 16;

  localparam logic [1:0] ADDR_IN   = 2'd0;
  localparam logic [1:0] ADDR_OUT  = 2'd1;
  localparam logic [1:0] ADDR_IE   = 2'd2;
  localparam logic [1:0] ADDR_PEND = 2'd3;

  // Mask with the low n bits set; n ranges 1..FW.
  function automatic logic [FW-1:0] low_mask(input int n);
    low_mask = FW'((32'd1 << n) - 32'd1);
  endfunction
endpackage

// File: rtl/wbgpio_infilter.sv
// Input conditioning: two-flop synchroniser, then an optional tick-sampled debounce.
// Latency 2 cycles without the filter; with it, two agreeing tick samples are needed.
module wbgpio_infilter #(
  parameter int NIN  = 16,
  parameter int DBLW = 0
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  input  logic           i_tick,
  input  logic [NIN-1:0] i_raw,
  output logic [NIN-1:0] o_filtered
);
  logic [NIN-1:0] r_meta;
  logic [NIN-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
    end
  end

  generate
    if (DBLW == 0) begin : g_nofilt
      logic w_unused_tick;
      assign w_unused_tick = i_tick;
      assign o_filtered    = r_sync;
    end else begin : g_debounce
      logic [NIN-1:0] r_samp;
      logic [NIN-1:0] r_filt;
      logic [NIN-1:0] w_agree;

      // A pin follows the input only once two consecutive tick samples match.
      assign w_agree = ~(r_sync ^ r_samp);

      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          r_samp <= '0;
          r_filt <= '0;
        end else if (i_tick) begin
          r_samp <= r_sync;
          r_filt <= (r_sync & w_agree) | (r_filt & ~w_agree);
        end
      end

      assign o_filtered = r_filt;
    end
  endgenerate
endmodule

// File: rtl/wbgpio_irq.sv
// Four-register pipelined Wishbone GPIO with edge interrupts; never stalls.
// Ack and read data one cycle after each request; o_int one cycle after pending changes.
module wbgpio_irq
  import wbgpio_pkg::*;
#(
  parameter int          NIN     = 16,
  parameter int          NOUT    = 16,
  parameter logic [FW-1:0] DEFAULT = 16'h0000,
  parameter int          DBLW    = 0
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_wb_cyc,
  input  logic            i_wb_stb,
  input  logic            i_wb_we,
  input  logic [1:0]      i_wb_addr,
  input  logic [31:0]     i_wb_data,
  output logic            o_wb_stall,
  output logic            o_wb_ack,
  output logic [31:0]     o_wb_data,
  input  logic [NIN-1:0]  i_gpio,
  output logic [NOUT-1:0] o_gpio,
  output logic            o_int
);
  localparam logic [FW-1:0] IN_MASK  = low_mask(NIN);
  localparam logic [FW-1:0] OUT_MASK = low_mask(NOUT);

  logic            w_tick;
  logic [NIN-1:0]  w_filt;
  logic [FW-1:0]   w_in;
  logic            w_req;
  logic            w_wr;
  logic [FW-1:0]   w_omask;
  logic [FW-1:0]   w_rise;
  logic [FW-1:0]   w_fall;
  logic [FW-1:0]   w_set;
  logic [FW-1:0]   w_clr;
  logic [31:0]     w_rdata;

  logic [FW-1:0]   r_out;
  logic [31:0]     r_ie;
  logic [FW-1:0]   r_pend;
  logic [FW-1:0]   r_prev;

  generate
    if (DBLW == 0) begin : g_notick
      assign w_tick = 1'b1;
    end else begin : g_presc
      logic [DBLW-1:0] r_presc;
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_presc <= '0;
        else            r_presc <= r_presc + DBLW'(1);
      end
      assign w_tick = &r_presc;
    end
  endgenerate

  wbgpio_infilter #(.NIN(NIN), .DBLW(DBLW)) u_infilter (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_tick     (w_tick),
    .i_raw      (i_gpio),
    .o_filtered (w_filt)
  );

  always_comb begin
    w_in            = '0;
    w_in[NIN-1:0]   = w_filt;
  end

  assign w_req   = i_wb_stb & i_wb_cyc;
  assign w_wr    = w_req & i_wb_we;
  assign w_omask = i_wb_data[31:16] & OUT_MASK;

  assign w_rise = w_in & ~r_prev;
  assign w_fall = ~w_in & r_prev;
  assign w_set  = (w_rise & r_ie[15:0]) | (w_fall & r_ie[31:16]);
  assign w_clr  = (w_wr && i_wb_addr == ADDR_PEND) ? i_wb_data[15:0] : '0;

  always_comb begin
    w_rdata = '0;
    case (i_wb_addr)
      ADDR_IN:  w_rdata = {16'h0, w_in};
      ADDR_OUT: w_rdata = {16'h0, r_out};
      ADDR_IE:  w_rdata = r_ie;
      default:  w_rdata = {16'h0, r_pend};
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_out     <= DEFAULT & OUT_MASK;
      r_ie      <= '0;
      r_pend    <= '0;
      r_prev    <= '0;
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
      o_int     <= 1'b0;
    end else begin
      o_wb_ack <= w_req;
      r_prev   <= w_in;
      // Set is applied after clear so a same-cycle edge is never lost.
      r_pend   <= w_set | (r_pend & ~w_clr);
      o_int    <= |r_pend;
      if (w_req) o_wb_data <= w_rdata;
      if (w_wr && i_wb_addr == ADDR_OUT) r_out <= (r_out & ~w_omask) | (i_wb_data[15:0] & w_omask);
      if (w_wr && i_wb_addr == ADDR_IE)  r_ie  <= i_wb_data & {IN_MASK, IN_MASK};
    end
  end

  assign o_wb_stall = 1'b0;
  assign o_gpio     = r_out[NOUT-1:0];
endmodule

// File: doc/wbgpio_irq.md
Name: wbgpio_irq

Overview:
- Parametrised successor to the single-register GPIO controller: up to 16 inputs and 16 outputs on a four-register pipelined Wishbone slave.
- Adds input synchronisation, an optional debounce filter, per-pin rising/falling-edge interrupt enables and sticky write-1-to-clear pending flags.
- Sits on the peripheral bus beside the other single-clock slaves; o_int feeds the interrupt controller.

Parameters:
- NIN, 16, number of input pins (1..16).
- NOUT, 16, number of output pins (1..16).
- DEFAULT, 16'h0000, reset value of o_gpio (low NOUT bits used).
- DBLW, 0, debounce prescaler width; 0 = no filter; else input sampled every 2^DBLW cycles.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_wb_cyc  in  1  bus cycle
- i_wb_stb  in  1  strobe
- i_wb_we  in  1  write enable
- i_wb_addr  in  2  register select
- i_wb_data  in  32  write data
- o_wb_stall  out  1  always 0
- o_wb_ack  out  1  acknowledge
- o_wb_data  out  32  read data
- i_gpio  in  NIN  raw asynchronous inputs
- o_gpio  out  NOUT  outputs
- o_int  out  1  interrupt, level, registered

Behaviour:
- Single clock i_clk; reset is asynchronous and active-low (i_reset_n); all flops clear on assertion regardless of clock.
- Reset values: o_gpio=DEFAULT, o_wb_ack=0, o_wb_data=0, o_int=0, IE=0, PEND=0, prescaler=0, filtered inputs=0, sync flops=0.
- Bus: a request is stb&&cyc. o_wb_ack=1 exactly one cycle after each request, including back-to-back requests; o_wb_stall tied 0. o_wb_data is registered, valid with ack, and updated only on requests.
- Reset mid-transaction drops any pending ack; no ack is issued for a request accepted before reset.
- Register map (addr):
  - 0 IN (RO): {16'h0, zero-extended filtered inputs}. Writes are ignored.
  - 1 OUT: write uses bits[31:16] as mask and bits[15:0] as value. o_gpio <= (o_gpio & ~mask) | (value & mask). Read returns {16'h0, zero-extended o_gpio}.
  - 2 IE (RW): bits[15:0] rising-edge enables, bits[31:16] falling-edge enables. Bits at or above NIN read 0 and are unwritable.
  - 3 PEND: read {16'h0, pending}. Writing 1 to bit[k] clears pending[k].
- Input path, per pin:
  - Two-flop synchroniser.
  - If DBLW=0, filtered = synchronised value, 2 cycles i_gpio->filtered.
  - Else a free-running prescaler issues a tick on wrap (all ones). On each tick, take a sample. filtered changes only when two consecutive tick samples agree and differ from filtered.
- Edge detect: prev <= filtered every cycle. rise=filtered&~prev; fall=~filtered&prev.
- Pending: set_k = (rise_k&IE[k]) | (fall_k&IE[16+k]). pending_k <= set_k | (pending_k & ~clear_k). A set and a clear in the same cycle leave the bit set (set wins).
- Enabling IE does not retroactively flag earlier edges.
- o_int <= |pending, so o_int rises 1 cycle after the pending bit sets and falls 1 cycle after the last bit clears.
- Write to OUT takes effect on o_gpio the cycle after the request. A read in the next request returns the new value.
- Widths: NIN/NOUT<16 zero-pad reads; write bits beyond NOUT/NIN are discarded.

Decomposition:
- Package wbgpio_pkg: register address constants ADDR_IN=0, ADDR_OUT=1, ADDR_IE=2, ADDR_PEND=3; the 16-bit field-width constant.
- Sub-module wbgpio_infilter(i_clk, i_reset_n, i_tick, i_raw, o_filtered), parametrised by NIN and DBLW. It holds the synchroniser and debounce.
- The top-level module holds the prescaler, registers, edge/pending logic and bus.

Test Plan:
- Reset with DEFAULT=16'h00A5 -> o_gpio=16'h00A5, o_int=0, o_wb_ack=0. Assert i_reset_n=0 mid-request -> no ack.
- Write OUT 32'h0003_0001, then 32'h0002_0000 -> o_gpio bit0=1, bit1=0, others unchanged. Read OUT -> 32'h0000_00A5 after the first write, and each ack is one cycle after stb.
- Back-to-back requests on 4 cycles (write IE 32'h0001_0001, read IE, read IN, read PEND) -> 4 consecutive acks, and IE reads 32'h0001_0001.
- DBLW=0, IE rise bit0 set, i_gpio[0] 0->1 -> PEND reads 32'h1, and o_int high 4 cycles after the pin change. Write PEND 32'h1 -> o_int low 2 cycles later.
- Simultaneous edge and clear: a falling edge on bit0 with the fall enable set, in the same cycle as a PEND write of 1 -> pending[0] stays 1.
- DBLW=2: a 3-cycle glitch on i_gpio[1] -> IN unchanged and no pending. A level held 12 cycles -> IN bit1=1.
